// File: rtl/alu_instr_sequencer_pkg.sv
// Shared widths, ALU opcodes and sequencer types for the alu_regfile issue stage.
package alu_instr_sequencer_pkg;

  localparam int REGFILE_WIDTH      = 8;
  localparam int ALU_OUTPUT_WIDTH   = 9;
  localparam int REGFILE_ADDR_WIDTH = 3;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_A = 3'd5
  } aluop_t;

  typedef enum logic {
    LOAD   = 1'b0,
    ALU_OP = 1'b1
  } instr_kind_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } seq_state_t;

  typedef struct packed {
    instr_kind_t                   kind;
    aluop_t                        op;
    logic [REGFILE_ADDR_WIDTH-1:0] dst;
    logic [REGFILE_ADDR_WIDTH-1:0] src1;
    logic [REGFILE_ADDR_WIDTH-1:0] src2;
    logic [REGFILE_WIDTH-1:0]      imm;
    logic                          use_carry;
  } instr_t;

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Instruction offer channel: valid/ready handshake plus the decoded instruction fields.
interface alu_instr_sequencer_if;
  import alu_instr_sequencer_pkg::*;

  logic                          instr_valid;
  logic                          instr_ready;
  instr_kind_t                   instr_kind;
  aluop_t                        instr_op;
  logic [REGFILE_ADDR_WIDTH-1:0] instr_dst;
  logic [REGFILE_ADDR_WIDTH-1:0] instr_src1;
  logic [REGFILE_ADDR_WIDTH-1:0] instr_src2;
  logic [REGFILE_WIDTH-1:0]      instr_imm;
  logic                          instr_use_carry;

  modport master (
    output instr_valid, instr_kind, instr_op, instr_dst, instr_src1, instr_src2,
           instr_imm, instr_use_carry,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_kind, instr_op, instr_dst, instr_src1, instr_src2,
           instr_imm, instr_use_carry,
    output instr_ready
  );

endinterface

// File: rtl/alu_instr_sequencer_fifo.sv
// Small instruction queue; the head entry is visible combinationally on pop_data.
module instr_fifo
  import alu_instr_sequencer_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = instr_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count disambiguates full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Issue stage for alu_regfile: queues instructions, sequences IDLE/EXEC/WB and
// tracks a carry flag across instructions for multi-precision chains.
module alu_instr_sequencer
  import alu_instr_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  alu_instr_sequencer_if.slave          instr_bus,
  output logic [REGFILE_ADDR_WIDTH-1:0] read_addr_1,
  output logic [REGFILE_ADDR_WIDTH-1:0] read_addr_2,
  output logic [REGFILE_ADDR_WIDTH-1:0] write_addr,
  output logic                          write_enable,
  output logic [REGFILE_WIDTH-1:0]      write_data,
  output logic                          carry_in,
  output aluop_t                        opcode,
  input  logic [ALU_OUTPUT_WIDTH-1:0]   alu_out,
  output logic                          result_valid,
  output logic [ALU_OUTPUT_WIDTH-1:0]   result,
  output logic                          carry_flag,
  output logic                          busy
);

  seq_state_t               state;
  seq_state_t               next_state;
  instr_t                   push_data;
  instr_t                   head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  instr_kind_t              cur_kind;
  logic [REGFILE_WIDTH-1:0] cur_imm;
  logic                     cur_use_carry;

  always_comb begin
    push_data           = '0;
    push_data.kind      = instr_bus.instr_kind;
    push_data.op        = instr_bus.instr_op;
    push_data.dst       = instr_bus.instr_dst;
    push_data.src1      = instr_bus.instr_src1;
    push_data.src2      = instr_bus.instr_src2;
    push_data.imm       = instr_bus.instr_imm;
    push_data.use_carry = instr_bus.instr_use_carry;
  end

  assign instr_bus.instr_ready = !fifo_full;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (instr_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (instr_bus.instr_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = (head.kind == ALU_OP) ? EXEC : WB;
        end
      end
      EXEC:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // LOAD sets Result at pop so it is already valid during its WB pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur_kind      <= LOAD;
      cur_imm       <= '0;
      cur_use_carry <= 1'b0;
      read_addr_1   <= '0;
      read_addr_2   <= '0;
      write_addr    <= '0;
      opcode        <= ALU_ADD;
      result        <= '0;
      carry_flag    <= 1'b0;
    end else begin
      state <= next_state;
      if (pop) begin
        cur_kind      <= head.kind;
        cur_imm       <= head.imm;
        cur_use_carry <= head.use_carry;
        write_addr    <= head.dst;
        if (head.kind == ALU_OP) begin
          read_addr_1 <= head.src1;
          read_addr_2 <= head.src2;
          opcode      <= head.op;
        end else begin
          result <= ALU_OUTPUT_WIDTH'(head.imm);
        end
      end
      if (state == EXEC) begin
        result     <= alu_out;
        carry_flag <= alu_out[ALU_OUTPUT_WIDTH-1];
      end
    end
  end

  assign write_enable = (state == WB);
  assign result_valid = (state == WB);
  assign carry_in     = (state == EXEC) && cur_use_carry && carry_flag;
  assign busy         = (state != IDLE) || !fifo_empty;

  always_comb begin
    write_data = '0;
    if (state == WB) write_data = (cur_kind == ALU_OP) ? result[REGFILE_WIDTH-1:0] : cur_imm;
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer with a behavioural regfile/ALU model on the far side.
module tb_alu_instr_sequencer;
  import alu_instr_sequencer_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [REGFILE_ADDR_WIDTH-1:0] read_addr_1, read_addr_2, write_addr;
  logic                          write_enable, carry_in, result_valid, carry_flag, busy;
  logic [REGFILE_WIDTH-1:0]      write_data;
  aluop_t                        opcode;
  logic [ALU_OUTPUT_WIDTH-1:0]   alu_out, result;

  logic [REGFILE_WIDTH-1:0] regs [8];
  logic [7:0]               log_addr [$];
  logic [7:0]               log_data [$];
  logic                     log_we [$];
  int                       carry_in_cycles = 0;
  int                       num_checks = 0;
  int                       num_errors = 0;

  alu_instr_sequencer_if instr_bus ();

  alu_instr_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_bus    (instr_bus),
    .read_addr_1  (read_addr_1),
    .read_addr_2  (read_addr_2),
    .write_addr   (write_addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .carry_in     (carry_in),
    .opcode       (opcode),
    .alu_out      (alu_out),
    .result_valid (result_valid),
    .result       (result),
    .carry_flag   (carry_flag),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (opcode)
      ALU_ADD: alu_out = {1'b0, regs[read_addr_1]} + {1'b0, regs[read_addr_2]} + 9'(carry_in);
      ALU_AND: alu_out = {1'b0, regs[read_addr_1] & regs[read_addr_2]};
      default: alu_out = '0;
    endcase
  end

  // Writebacks are logged mid-cycle and committed into the regfile model.
  always @(negedge clk) begin
    if (result_valid) begin
      log_addr.push_back(8'(write_addr));
      log_data.push_back(write_data);
      log_we.push_back(write_enable);
      regs[write_addr] <= write_data;
    end
    if (carry_in) carry_in_cycles <= carry_in_cycles + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input instr_kind_t kind, input aluop_t op, input int dst,
                               input int src1, input int src2, input int imm, input logic uc);
    int n;
    instr_bus.instr_kind      = kind;
    instr_bus.instr_op        = op;
    instr_bus.instr_dst       = 3'(dst);
    instr_bus.instr_src1      = 3'(src1);
    instr_bus.instr_src2      = 3'(src2);
    instr_bus.instr_imm       = 8'(imm);
    instr_bus.instr_use_carry = uc;
    instr_bus.instr_valid     = 1'b1;
    n = 0;
    while (!instr_bus.instr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("ready_timeout", 32'(instr_bus.instr_ready), 32'd1);
    @(posedge clk);
    #1;
    instr_bus.instr_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  task automatic checkWb(input int idx, input int exp_addr, input int exp_data);
    if (idx < log_data.size()) begin
      checkOutput($sformatf("wb%0d_addr", idx), 32'(log_addr[idx]), 32'(exp_addr));
      checkOutput($sformatf("wb%0d_data", idx), 32'(log_data[idx]), 32'(exp_data));
      checkOutput($sformatf("wb%0d_we", idx), 32'(log_we[idx]), 32'd1);
    end else begin
      checkOutput($sformatf("wb%0d_missing", idx), 32'(log_data.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int base;
    int cin_base;
    rst                       = 1'b1;
    instr_bus.instr_valid     = 1'b0;
    instr_bus.instr_kind      = LOAD;
    instr_bus.instr_op        = ALU_ADD;
    instr_bus.instr_dst       = '0;
    instr_bus.instr_src1      = '0;
    instr_bus.instr_src2      = '0;
    instr_bus.instr_imm       = '0;
    instr_bus.instr_use_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(instr_bus.instr_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_we", 32'(write_enable), 32'd0);
    checkOutput("rst_rvalid", 32'(result_valid), 32'd0);
    checkOutput("rst_carry", 32'(carry_flag), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);
    checkOutput("rst_raddr1", 32'(read_addr_1), 32'd0);

    $display("[TB] load then add");
    base = log_data.size();
    applyStimulus(LOAD, ALU_ADD, 1, 0, 0, 8'h05, 1'b0);
    applyStimulus(LOAD, ALU_ADD, 2, 0, 0, 8'h03, 1'b0);
    applyStimulus(ALU_OP, ALU_ADD, 3, 1, 2, 0, 1'b0);
    waitIdle("t1_idle");
    checkOutput("t1_wb_count", 32'(log_data.size() - base), 32'd3);
    checkWb(base + 0, 1, 8'h05);
    checkWb(base + 1, 2, 8'h03);
    checkWb(base + 2, 3, 8'h08);
    checkOutput("t1_result", 32'(result), 32'h008);
    checkOutput("t1_carry", 32'(carry_flag), 32'd0);

    $display("[TB] carry chain");
    base = log_data.size();
    applyStimulus(LOAD, ALU_ADD, 1, 0, 0, 8'hFF, 1'b0);
    applyStimulus(LOAD, ALU_ADD, 2, 0, 0, 8'h01, 1'b0);
    applyStimulus(ALU_OP, ALU_ADD, 3, 1, 2, 0, 1'b0);
    waitIdle("t2a_idle");
    checkWb(base + 2, 3, 8'h00);
    checkOutput("t2_result_ovf", 32'(result), 32'h100);
    checkOutput("t2_carry_set", 32'(carry_flag), 32'd1);
    applyStimulus(LOAD, ALU_ADD, 0, 0, 0, 8'h00, 1'b0);
    waitIdle("t2b_idle");
    checkOutput("t2_carry_kept", 32'(carry_flag), 32'd1);
    cin_base = carry_in_cycles;
    applyStimulus(ALU_OP, ALU_ADD, 4, 0, 0, 0, 1'b1);
    waitIdle("t2c_idle");
    checkOutput("t2_cin_cycles", 32'(carry_in_cycles - cin_base), 32'd1);
    checkWb(base + 4, 4, 8'h01);
    checkOutput("t2_carry_clr", 32'(carry_flag), 32'd0);

    $display("[TB] back-pressure");
    base = log_data.size();
    applyStimulus(ALU_OP, ALU_ADD, 5, 2, 2, 0, 1'b0);
    applyStimulus(ALU_OP, ALU_ADD, 6, 4, 2, 0, 1'b0);
    applyStimulus(ALU_OP, ALU_ADD, 7, 1, 0, 0, 1'b0);
    applyStimulus(ALU_OP, ALU_ADD, 5, 5, 5, 0, 1'b0);
    applyStimulus(ALU_OP, ALU_ADD, 6, 6, 2, 0, 1'b0);
    applyStimulus(ALU_OP, ALU_ADD, 7, 7, 2, 0, 1'b0);
    @(negedge clk);
    checkOutput("t3_ready_full", 32'(instr_bus.instr_ready), 32'd0);
    checkOutput("t3_busy", 32'(busy), 32'd1);
    waitIdle("t3_idle");
    checkOutput("t3_wb_count", 32'(log_data.size() - base), 32'd6);
    checkWb(base + 0, 5, 8'h02);
    checkWb(base + 1, 6, 8'h02);
    checkWb(base + 2, 7, 8'hFF);
    checkWb(base + 3, 5, 8'h04);
    checkWb(base + 4, 6, 8'h03);
    checkWb(base + 5, 7, 8'h00);
    checkOutput("t3_carry", 32'(carry_flag), 32'd1);
    checkOutput("t3_ready_after", 32'(instr_bus.instr_ready), 32'd1);

    $display("[TB] wrap-around");
    base = log_data.size();
    for (int i = 0; i < 10; i++) applyStimulus(LOAD, ALU_ADD, i % 8, 0, 0, i, 1'b0);
    waitIdle("t4_idle");
    checkOutput("t4_wb_count", 32'(log_data.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) checkWb(base + i, i % 8, i);
    checkOutput("t4_result", 32'(result), 32'd9);
    checkOutput("t4_carry_kept", 32'(carry_flag), 32'd1);

    $display("[TB] reset mid-op");
    applyStimulus(ALU_OP, ALU_ADD, 3, 1, 2, 0, 1'b1);
    applyStimulus(LOAD, ALU_ADD, 7, 0, 0, 8'hAA, 1'b0);
    checkOutput("t5_in_exec_cin", 32'(carry_in), 32'd1);
    base = log_data.size();
    rst = 1'b1;
    #1;
    checkOutput("t5_ready", 32'(instr_bus.instr_ready), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_carry", 32'(carry_flag), 32'd0);
    checkOutput("t5_cin", 32'(carry_in), 32'd0);
    checkOutput("t5_we", 32'(write_enable), 32'd0);
    checkOutput("t5_result", 32'(result), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t5_no_wb", 32'(log_data.size() - base), 32'd0);
    checkOutput("t5_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
